// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg: shared width codes, FSM states and request-legality helper.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package lsu_pkg;

  localparam int LSU_XLEN = 32;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT_R = 2'd2,
    ST_RESP   = 2'd3
  } lsu_state_e;

  // Unsigned codes exist only for loads; any other code is illegal.
  function automatic logic lsu_req_err(input logic       we,
                                       input logic [2:0] funct3,
                                       input logic [1:0] addr_lo);
    logic err;
    err = 1'b1;
    case (funct3)
      F3_B:    err = 1'b0;
      F3_H:    err = addr_lo[0];
      F3_W:    err = (addr_lo != 2'b00);
      F3_BU:   err = we;
      F3_HU:   err = we | addr_lo[0];
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_if.sv
// ---------------------------------------------------------------------------
// lsu_if: pipeline request/response and memory bus signals of the LSU.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface lsu_if #(
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = DATA_WIDTH / 8
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [DATA_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;

  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;

  logic                  mem_req;
  logic                  mem_gnt;
  logic [DATA_WIDTH-1:0] mem_a;
  logic                  mem_we;
  logic [BE_WIDTH-1:0]   mem_be;
  logic [DATA_WIDTH-1:0] mem_wd;
  logic                  mem_rvalid;
  logic [DATA_WIDTH-1:0] mem_rd;

  // LSU side
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  mem_gnt, mem_rvalid, mem_rd,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_req, mem_a, mem_we, mem_be, mem_wd
  );

  // Pipeline + memory environment side
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    output mem_gnt, mem_rvalid, mem_rd,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_req, mem_a, mem_we, mem_be, mem_wd
  );

endinterface

`default_nettype wire

// File: rtl/lsu_load_align.sv
// ---------------------------------------------------------------------------
// lsu_load_align: selects byte/half from a read word and extends it.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] mem_rd,
  input  logic [1:0]            addr_lo,
  input  logic [2:0]            funct3,
  output logic [DATA_WIDTH-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = mem_rd[7:0];
      2'd1:    byte_sel = mem_rd[15:8];
      2'd2:    byte_sel = mem_rd[23:16];
      default: byte_sel = mem_rd[31:24];
    endcase
    half_sel = addr_lo[1] ? mem_rd[31:16] : mem_rd[15:0];
  end

  always_comb begin
    data = mem_rd;
    case (funct3)
      F3_B:    data = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
      F3_H:    data = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
      F3_BU:   data = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
      F3_HU:   data = {{(DATA_WIDTH-16){1'b0}}, half_sel};
      default: data = mem_rd;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/lsu_core.sv
// ---------------------------------------------------------------------------
// lsu_core: single-outstanding RV32I load/store unit with registered bus.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lsu_core
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic  clk,
  input  logic  rst,
  lsu_if.slave  bus
);

  lsu_state_e            state_q, state_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [1:0]            addr_lo_q, addr_lo_d;
  logic                  mem_req_q, mem_req_d;
  logic [DATA_WIDTH-1:0] mem_a_q, mem_a_d;
  logic                  mem_we_q, mem_we_d;
  logic [BE_WIDTH-1:0]   mem_be_q, mem_be_d;
  logic [DATA_WIDTH-1:0] mem_wd_q, mem_wd_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_err_q, resp_err_d;
  logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;

  logic                  accept;
  logic                  req_err;
  logic [3:0]            st_be;
  logic [DATA_WIDTH-1:0] st_wd;
  logic [DATA_WIDTH-1:0] load_data;

  assign accept  = bus.req_valid && (state_q == ST_IDLE);
  assign req_err = lsu_req_err(bus.req_we, bus.req_funct3, bus.req_addr[1:0]);

  // Store lanes: narrow data is replicated so every enabled lane sees it.
  always_comb begin
    st_be = 4'b1111;
    st_wd = bus.req_wdata;
    case (bus.req_funct3[1:0])
      2'b00: begin
        st_be = 4'b0001 << bus.req_addr[1:0];
        st_wd = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        st_be = 4'b0011 << bus.req_addr[1:0];
        st_wd = {2{bus.req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  lsu_load_align #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_load_align (
    .mem_rd  (bus.mem_rd),
    .addr_lo (addr_lo_q),
    .funct3  (funct3_q),
    .data    (load_data)
  );

  always_comb begin
    state_d      = state_q;
    funct3_d     = funct3_q;
    addr_lo_d    = addr_lo_q;
    mem_req_d    = 1'b0;
    mem_a_d      = mem_a_q;
    mem_we_d     = mem_we_q;
    mem_be_d     = mem_be_q;
    mem_wd_d     = mem_wd_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = '0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          funct3_d  = bus.req_funct3;
          addr_lo_d = bus.req_addr[1:0];
          if (req_err) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            state_d   = ST_ISSUE;
            mem_req_d = 1'b1;
            mem_a_d   = {bus.req_addr[DATA_WIDTH-1:2], 2'b00};
            mem_we_d  = bus.req_we;
            mem_be_d  = BE_WIDTH'(st_be);
            mem_wd_d  = bus.req_we ? st_wd : '0;
          end
        end
      end
      ST_ISSUE: begin
        if (bus.mem_gnt) begin
          mem_a_d  = '0;
          mem_we_d = 1'b0;
          mem_be_d = '0;
          mem_wd_d = '0;
          if (mem_we_q) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
          end else begin
            state_d = ST_WAIT_R;
          end
        end else begin
          mem_req_d = 1'b1;
        end
      end
      ST_WAIT_R: begin
        if (bus.mem_rvalid) begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = load_data;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      funct3_q     <= '0;
      addr_lo_q    <= '0;
      mem_req_q    <= 1'b0;
      mem_a_q      <= '0;
      mem_we_q     <= 1'b0;
      mem_be_q     <= '0;
      mem_wd_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      funct3_q     <= funct3_d;
      addr_lo_q    <= addr_lo_d;
      mem_req_q    <= mem_req_d;
      mem_a_q      <= mem_a_d;
      mem_we_q     <= mem_we_d;
      mem_be_q     <= mem_be_d;
      mem_wd_q     <= mem_wd_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign bus.req_ready  = (state_q == ST_IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_a      = mem_a_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_be     = mem_be_q;
  assign bus.mem_wd     = mem_wd_q;

endmodule

`default_nettype wire

// File: doc/lsu_core.md
LSU_CORE -- requirements
Module: lsu_core

Interface
REQ-001 Parameter DATA_WIDTH, default 32: data and address width; only 32 is supported.
REQ-002 Parameter BE_WIDTH, default DATA_WIDTH/8: byte-enable width.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req_valid  input  1  the pipeline presents a load/store request.
REQ-006 req_ready  output  1  the LSU accepts the request this cycle.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_funct3  input  3  RV32I width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 req_addr  input  DATA_WIDTH  byte address.
REQ-010 req_wdata  input  DATA_WIDTH  store data, LSB-aligned.
REQ-011 resp_valid  output  1  one-cycle pulse: the access has completed.
REQ-012 resp_rdata  output  DATA_WIDTH  extended load result; 0 for stores and errors.
REQ-013 resp_err  output  1  misaligned access or illegal funct3, qualified by resp_valid.
REQ-014 mem_req  output  1  memory access request.
REQ-015 mem_gnt  input  1  the memory accepts mem_req this cycle.
REQ-016 mem_a  output  DATA_WIDTH  word-aligned address (addr[1:0] = 00).
REQ-017 mem_we  output  1  write enable.
REQ-018 mem_be  output  BE_WIDTH  byte lanes to write.
REQ-019 mem_wd  output  DATA_WIDTH  lane-shifted store data.
REQ-020 mem_rvalid  input  1  read data valid; arrives 1 or more cycles after the load grant.
REQ-021 mem_rd  input  DATA_WIDTH  full read word.

Function
REQ-022 The FSM SHALL have states IDLE, ISSUE, WAIT_R and RESP.
REQ-023 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid && req_ready, and its fields are latched.
REQ-024 On acceptance, the LSU SHALL go to RESP with err=1 and issue no memory access if the request is misaligned (H with addr[0]=1; W with addr[1:0]!=0) or has an illegal funct3 (011, 110, 111, or any store code above 010); otherwise it SHALL go to ISSUE.
REQ-025 In ISSUE, mem_req SHALL be 1 with mem_a/mem_we/mem_be/mem_wd stable until mem_gnt; on a store grant the LSU goes to RESP, on a load grant to WAIT_R.
REQ-026 Byte enables SHALL be: B = 0001<<addr[1:0]; H = 0011<<addr[1:0]; W = 1111.
REQ-027 Store lane data SHALL be: mem_wd = wdata replicated per lane (B: 4x byte; H: 2x half).
REQ-028 Load lane data: in WAIT_R, on mem_rvalid, the LSU SHALL select the byte/half at addr[1:0], sign-extend (B, H) or zero-extend (BU, HU), register the result, and go to RESP.
REQ-029 RESP SHALL assert resp_valid for exactly one cycle, then return to IDLE.
REQ-030 Minimum latency from acceptance to resp_valid SHALL be 2 cycles for a store (grant in the first ISSUE cycle) and 3 cycles for a load (rvalid in the cycle after the grant); an error response SHALL occur 1 cycle after acceptance.
REQ-031 mem_req SHALL be 0 outside ISSUE; mem_rvalid outside WAIT_R SHALL be ignored.
REQ-032 A new request SHALL NOT be accepted in the same cycle as resp_valid (back-to-back throughput is one access per 3+ cycles).

Reset
REQ-033 While rst=1, the FSM SHALL be IDLE and every registered output SHALL be 0 (resp_valid, resp_rdata, resp_err, mem_req, mem_we, mem_be, mem_a, mem_wd); req_ready SHALL be 1 one cycle after deassertion.
REQ-034 Reset mid-access SHALL abandon the access immediately; a later mem_rvalid SHALL produce no response.

Structure
REQ-035 A shared package lsu_pkg SHALL hold the funct3 width codes enum and the FSM state enum.
REQ-036 One combinational sub-module, lsu_load_align (mem_rd, addr[1:0], funct3 -> extended data), is natural; the store lane logic SHALL stay inline.

Verification
REQ-037 LB at 0x0000_0003, mem_rd 0x80FF_FF7F -> resp_rdata 0xFFFF_FF80, err=0, resp_valid 3 cycles after acceptance.
REQ-038 SH at 0x0000_0002, wdata 0x1234_ABCD -> mem_be 1100, mem_wd 0xABCD_ABCD, mem_a 0x0, mem_we=1.
REQ-039 LW at 0x0000_0006 -> mem_req never asserted, resp_valid+resp_err 1 cycle later, rdata 0.
REQ-040 Store with mem_gnt held low 4 cycles -> mem_req and mem bus stable for 5 cycles, req_ready=0 throughout.
REQ-041 LHU at 0x0000_0002, mem_rd 0x8001_0000, rvalid delayed 3 cycles -> resp_rdata 0x0000_8001.
REQ-042 rst pulsed during WAIT_R, then stray mem_rvalid -> no resp_valid, all outputs 0, req_ready=1 the next cycle.
